// File: rtl/cnn_pkg.sv
// Shared definitions for the super-resolution CNN datapath controllers:
// layer state codes, default layer sizes and the frame sizes used by the fmap counter.
package cnn_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    PADDING = 4'd1,
    CONV1   = 4'd2,
    RES_1   = 4'd3,
    RES_2   = 4'd4,
    UP_1    = 4'd5,
    UP_2    = 4'd6,
    CONV2   = 4'd7,
    FINISH  = 4'd8
  } layer_state_t;

  localparam int FMAPS_STD_DEF = 24;
  localparam int FMAPS_UP_DEF  = 96;
  localparam int DRAIN_CYC_DEF = 5;

  // Pixel counts of the low-res input, x2 and x4 upscaled frames.
  localparam int FRAME_PIX_LR = 14400;
  localparam int FRAME_PIX_X2 = 57600;
  localparam int FRAME_PIX_X4 = 230400;

  function automatic logic is_up_layer(input layer_state_t s);
    return (s == UP_1) || (s == UP_2);
  endfunction

endpackage

// File: rtl/cnn_drain_timer.sv
// Pipeline-drain window timer: a load pulse opens a window of DRAIN_CYC cycles,
// busy is high throughout it and expire marks its last cycle.
module cnn_drain_timer #(
  parameter int DRAIN_CYC = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  output logic busy,
  output logic expire
);

  localparam int            CW       = $clog2(DRAIN_CYC + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(DRAIN_CYC);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign expire = (cnt_q == ONE);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Layer scheduler for the super-resolution CNN: walks PADDING, CONV1, N_RES residual
// pairs, UP_1, UP_2, CONV2, FINISH. Define SEQ_CYCLE_CNT_EN to add the cycle_cnt output.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int N_RES     = 4,
  parameter int FMAPS_STD = FMAPS_STD_DEF,
  parameter int FMAPS_UP  = FMAPS_UP_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       padding_done,
  input  logic       fmap_end,
  output logic [3:0] state,
  output logic       layer_start,
  output logic [3:0] res_iter,
  output logic [6:0] fmap_cnt,
  output logic       draining,
  output logic       busy,
  output logic       done
`ifdef SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0] cycle_cnt
`endif
);

  localparam logic [6:0] STD_LIM  = 7'(FMAPS_STD);
  localparam logic [6:0] UP_LIM   = 7'(FMAPS_UP);
  localparam logic [3:0] RES_LAST = 4'(N_RES - 1);

  layer_state_t state_q, state_d;
  logic [3:0]   res_iter_q, res_iter_d;
  logic [6:0]   fmap_cnt_q, fmap_cnt_d;
  logic         layer_start_q, layer_start_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [6:0]   fmap_limit;
  logic         drain_load, drain_clear, drain_busy, drain_expire;

  cnn_drain_timer #(
    .DRAIN_CYC(DRAIN_CYC)
  ) u_drain (
    .clk   (clk),
    .rst   (rst),
    .clear (drain_clear),
    .load  (drain_load),
    .busy  (drain_busy),
    .expire(drain_expire)
  );

  always_comb begin
    state_d       = state_q;
    res_iter_d    = res_iter_q;
    fmap_cnt_d    = fmap_cnt_q;
    layer_start_d = 1'b0;
    drain_load    = 1'b0;
    drain_clear   = 1'b0;
    fmap_limit    = is_up_layer(state_q) ? UP_LIM : STD_LIM;

    case (state_q)
      IDLE: begin
        if (start && !abort) state_d = PADDING;
      end
      PADDING: begin
        if (padding_done) begin
          state_d       = CONV1;
          layer_start_d = 1'b1;
        end
      end
      CONV1, RES_1, RES_2, UP_1, UP_2, CONV2: begin
        if (drain_expire) begin
          fmap_cnt_d    = '0;
          layer_start_d = 1'b1;
          case (state_q)
            CONV1: state_d = RES_1;
            RES_1: state_d = RES_2;
            RES_2: begin
              if (res_iter_q < RES_LAST) begin
                state_d    = RES_1;
                res_iter_d = res_iter_q + 4'd1;
              end else begin
                state_d    = UP_1;
                res_iter_d = '0;
              end
            end
            UP_1: state_d = UP_2;
            UP_2: state_d = CONV2;
            default: begin
              state_d       = FINISH;
              layer_start_d = 1'b0;
            end
          endcase
        end else if (fmap_end && !drain_busy && (fmap_cnt_q < fmap_limit)) begin
          fmap_cnt_d = fmap_cnt_q + 7'd1;
          drain_load = (fmap_cnt_d == fmap_limit);
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort drops the image from any active state; a same-cycle fmap_end is discarded.
    if (abort && (state_q != IDLE)) begin
      state_d       = IDLE;
      res_iter_d    = '0;
      fmap_cnt_d    = '0;
      layer_start_d = 1'b0;
      drain_load    = 1'b0;
      drain_clear   = 1'b1;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      res_iter_q    <= '0;
      fmap_cnt_q    <= '0;
      layer_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      res_iter_q    <= res_iter_d;
      fmap_cnt_q    <= fmap_cnt_d;
      layer_start_q <= layer_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign state       = state_q;
  assign res_iter    = res_iter_q;
  assign fmap_cnt    = fmap_cnt_q;
  assign layer_start = layer_start_q;
  assign draining    = drain_busy;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef SEQ_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  // Counts active cycles of one image; frozen in FINISH/IDLE and kept across abort.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (state_q == IDLE) begin
      if (start && !abort) cycle_cnt_d = '0;
    end else if ((state_q != FINISH) && !abort && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cycle_cnt_q <= '0;
    else     cycle_cnt_q <= cycle_cnt_d;
  end

  assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Randomized bench for cnn_layer_sequencer against a layer-list reference model.
// Honours SEQ_CYCLE_CNT_EN when the design is built with it.
module tb_cnn_layer_sequencer;

  localparam int N_RES     = 3;
  localparam int FMAPS_STD = 24;
  localparam int FMAPS_UP  = 96;
  localparam int DRAIN_CYC = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       padding_done;
  logic       fmap_end;
  logic [3:0] state;
  logic       layer_start;
  logic [3:0] res_iter;
  logic [6:0] fmap_cnt;
  logic       draining;
  logic       busy;
  logic       done;
`ifdef SEQ_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cnn_layer_sequencer #(
    .N_RES    (N_RES),
    .FMAPS_STD(FMAPS_STD),
    .FMAPS_UP (FMAPS_UP),
    .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .padding_done(padding_done),
    .fmap_end    (fmap_end),
    .state       (state),
    .layer_start (layer_start),
    .res_iter    (res_iter),
    .fmap_cnt    (fmap_cnt),
    .draining    (draining),
    .busy        (busy),
    .done        (done)
`ifdef SEQ_CYCLE_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt)
`endif
  );

  // Reference model: the image is a list of compute layers walked in order.
  typedef enum int {PH_IDLE, PH_PAD, PH_LAYER, PH_FIN} phase_t;
  int     seq_code[$];
  int     seq_res[$];
  phase_t m_phase;
  int     m_pos;
  int     m_cnt;
  int     m_drain;
  logic   m_ls;
`ifdef SEQ_CYCLE_CNT_EN
  int     m_cyc;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d at time %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int layerLimit(input int code);
    return (code == 5 || code == 6) ? FMAPS_UP : FMAPS_STD;
  endfunction

  function automatic void buildSequence();
    seq_code.push_back(2); seq_res.push_back(0);
    for (int r = 0; r < N_RES; r++) begin
      seq_code.push_back(3); seq_res.push_back(r);
      seq_code.push_back(4); seq_res.push_back(r);
    end
    seq_code.push_back(5); seq_res.push_back(0);
    seq_code.push_back(6); seq_res.push_back(0);
    seq_code.push_back(7); seq_res.push_back(0);
  endfunction

  task automatic modelStep();
    m_ls = 1'b0;
    if (rst) begin
      m_phase = PH_IDLE; m_pos = 0; m_cnt = 0; m_drain = 0;
`ifdef SEQ_CYCLE_CNT_EN
      m_cyc = 0;
`endif
    end else if (abort && m_phase != PH_IDLE) begin
      m_phase = PH_IDLE; m_pos = 0; m_cnt = 0; m_drain = 0;
    end else begin
`ifdef SEQ_CYCLE_CNT_EN
      if (m_phase == PH_PAD || m_phase == PH_LAYER) m_cyc++;
`endif
      case (m_phase)
        PH_IDLE: begin
          if (start && !abort) begin
            m_phase = PH_PAD;
`ifdef SEQ_CYCLE_CNT_EN
            m_cyc = 0;
`endif
          end
        end
        PH_PAD: begin
          if (padding_done) begin
            m_phase = PH_LAYER; m_pos = 0; m_cnt = 0; m_ls = 1'b1;
          end
        end
        PH_LAYER: begin
          if (m_drain == 1) begin
            m_drain = 0; m_cnt = 0; m_pos++;
            if (m_pos == seq_code.size()) m_phase = PH_FIN;
            else m_ls = 1'b1;
          end else if (m_drain > 1) begin
            m_drain--;
          end else if (fmap_end) begin
            m_cnt++;
            if (m_cnt == layerLimit(seq_code[m_pos])) m_drain = DRAIN_CYC;
          end
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  endtask

  task automatic compareAll();
    int exp_state;
    int exp_res;
    exp_res = 0;
    case (m_phase)
      PH_IDLE:  exp_state = 0;
      PH_PAD:   exp_state = 1;
      PH_LAYER: begin exp_state = seq_code[m_pos]; exp_res = seq_res[m_pos]; end
      default:  exp_state = 8;
    endcase
    checkOutput("state", 32'(state), exp_state);
    checkOutput("res_iter", 32'(res_iter), exp_res);
    checkOutput("fmap_cnt", 32'(fmap_cnt), m_cnt);
    checkOutput("draining", 32'(draining), 32'(m_drain > 0));
    checkOutput("layer_start", 32'(layer_start), 32'(m_ls));
    checkOutput("busy", 32'(busy), 32'(m_phase != PH_IDLE));
    checkOutput("done", 32'(done), 32'(m_phase == PH_FIN));
`ifdef SEQ_CYCLE_CNT_EN
    checkOutput("cycle_cnt", cycle_cnt, m_cyc);
`endif
  endtask

  always @(posedge clk) begin
    modelStep();
    #1;
    compareAll();
  end

  // mode 0: full image, 1: abort on the last fmap_end of the first RES_1, 2: rst in UP_2 at count 50
  task automatic applyStimulus(input int mode);
    int budget;
    int pad_wait;
    int ls_seen;
    bit hit;
    budget = 4000; pad_wait = 10; ls_seen = 0; hit = 1'b0;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; fmap_end = 1'b0; padding_done = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (budget > 0) begin
      budget--;
      if (layer_start === 1'b1) ls_seen++;
      if (m_phase == PH_IDLE) break;
      fmap_end     = ($urandom_range(0, 2) == 0);
      start        = ($urandom_range(0, 15) == 0);
      abort        = 1'b0;
      rst          = 1'b0;
      padding_done = 1'b0;
      if (m_phase == PH_PAD) begin
        if (pad_wait == 0) padding_done = 1'b1;
        else pad_wait--;
      end
      if (mode == 1 && !hit && m_phase == PH_LAYER && seq_code[m_pos] == 3 && m_cnt == FMAPS_STD - 1) begin
        fmap_end = 1'b1; abort = 1'b1; hit = 1'b1;
      end
      if (mode == 2 && !hit && m_phase == PH_LAYER && seq_code[m_pos] == 6 && m_cnt == 50) begin
        rst = 1'b1; hit = 1'b1;
      end
      @(negedge clk);
    end
    fmap_end = 1'b0; start = 1'b0; abort = 1'b0; rst = 1'b0; padding_done = 1'b0;
    if (budget == 0) checkOutput("image_timeout", 32'd0, 32'd1);
    if (mode == 0) checkOutput("layer_start_count", ls_seen, seq_code.size());
    else checkOutput("early_exit_taken", 32'(hit), 32'd1);
  endtask

  task automatic idleProbe(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      fmap_end = ($urandom_range(0, 1) == 1);
      start    = 1'b1;
      abort    = 1'b1;
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; fmap_end = 1'b0;
    checkOutput("idle_start_abort", 32'(state), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; padding_done = 1'b0; fmap_end = 1'b0;
    buildSequence();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idleProbe(4);
    applyStimulus(0);
    repeat (5) @(negedge clk);
    applyStimulus(1);
    applyStimulus(0);
    applyStimulus(2);
    idleProbe(3);
    applyStimulus(0);
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
Top-level layer scheduler for the super-resolution CNN datapath. It produces the 4-bit layer `state` consumed by the fmap counter, conv engines and buffers. It advances the pipeline through PADDING, CONV1, a configurable number of RES_1/RES_2 residual pairs, UP_1, UP_2, CONV2 and FINISH. For each layer it counts `fmap_end` pulses and holds the layer for a pipeline-drain window before moving on.

Parameters:
- N_RES, 4, number of RES_1/RES_2 pairs executed (1..15)
- FMAPS_STD, 24, fmap_end pulses that complete CONV1/RES_1/RES_2/CONV2
- FMAPS_UP, 96, fmap_end pulses that complete UP_1/UP_2
- DRAIN_CYC, 5, cycles held in a layer after its last fmap_end (pipeline flush)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin one image; sampled only in IDLE
- abort  in  1  abandon the current image; return to IDLE
- padding_done  in  1  pulse from the padding engine; input frame written
- fmap_end  in  1  pulse from the counter; one output fmap finished
- state  out  4  layer code: IDLE=0, PADDING=1, CONV1=2, RES_1=3, RES_2=4, UP_1=5, UP_2=6, CONV2=7, FINISH=8
- layer_start  out  1  one-cycle pulse in the first cycle of each compute layer (states 2..7)
- res_iter  out  4  current residual pair index, 0..N_RES-1
- fmap_cnt  out  7  fmap_end pulses seen in the current layer
- draining  out  1  high during the drain window
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, high exactly while state == FINISH

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are registered.
- Reset values: state=IDLE, res_iter=0, fmap_cnt=0, draining=0, layer_start=0, busy=0, done=0, internal drain counter=0.
- Reset asserted mid-image overrides everything and takes effect at the next edge.
- IDLE -> PADDING: on the edge where start=1.
- PADDING -> CONV1: on the edge where padding_done=1; layer_start=1 in the first CONV1 cycle.
- Compute states (2..7):
  - Each fmap_end increments fmap_cnt.
  - Limit is FMAPS_UP in UP_1/UP_2 and FMAPS_STD otherwise.
  - When the increment reaches the limit, fmap_cnt holds at the limit and draining=1 from the next cycle.
  - draining stays high for exactly DRAIN_CYC cycles. The transition happens on the edge ending the last drain cycle.
  - On transition, fmap_cnt is cleared to 0 and the next state's first cycle carries layer_start=1.
- fmap_end pulses arriving while draining=1, or outside compute states, are ignored (no count change).
- Next-state order:
  - CONV1 -> RES_1 -> RES_2.
  - RES_2 -> RES_1 with res_iter+1 if res_iter < N_RES-1.
  - Otherwise RES_2 -> UP_1 with res_iter cleared to 0.
  - UP_1 -> UP_2 -> CONV2 -> FINISH.
- FINISH lasts exactly one cycle (done=1), then IDLE.
- start outside IDLE is ignored. start and abort together in IDLE: abort wins, stay IDLE.
- abort in any non-IDLE state: IDLE on the next edge; all counters cleared; no done pulse.
- A fmap_end in the same cycle as abort is discarded.
- Latency example, N_RES=1: last fmap_end of CONV2 at cycle T gives draining during T+1..T+5, FINISH at T+6, IDLE at T+7.

Optional Feature:
- Macro: SEQ_CYCLE_CNT_EN.
- When defined:
  - Adds output cycle_cnt [31:0].
  - Cleared on the edge that leaves IDLE on start.
  - Increments every cycle while busy, saturating at 2^32-1.
  - Frozen at its final value in FINISH and IDLE until the next start.
  - Cleared by rst. Retains its value on abort.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cnn_pkg holds:
  - the state encodings IDLE..FINISH (4-bit typedef `layer_state_t`);
  - FMAPS_STD, FMAPS_UP and DRAIN_CYC defaults;
  - the frame sizes used by the counter (14400, 57600, 230400 pixels).
- Sub-module cnn_drain_timer holds the drain counter. Interface: load pulse, busy flag, expire pulse. It is reused by other flush-sensitive controllers.
- The next-state FSM stays in this module.

Test Plan:
- Reset then start, N_RES=1, padding_done after 10 cycles, 24/24/24/96/96/24 fmap_end pulses spaced 3 cycles -> state walks 0,1,2,3,4,5,6,7,8,0; six layer_start pulses; done high exactly 1 cycle, 6 cycles after the last fmap_end.
- N_RES=3 -> RES_1/RES_2 visited 3 times, res_iter shows 0,1,2, returns to 0 on entering UP_1.
- fmap_end pulses injected during draining, in PADDING and in IDLE -> fmap_cnt unchanged; drain length still 5 cycles.
- abort on the cycle of the 24th RES_1 fmap_end -> state=0 next cycle, fmap_cnt=0, res_iter=0, no done; subsequent start runs a full image normally.
- rst pulsed mid-UP_2 with fmap_cnt=50 -> all outputs at reset values the next cycle; start during busy ignored.
- SEQ_CYCLE_CNT_EN defined, N_RES=1, fixed stimulus -> cycle_cnt equals the cycle count from start edge to FINISH; unchanged 20 cycles later in IDLE.
